cpu_busctl: RTL and testbench
=============================

CPU_BUSCTL -- requirements
Module: cpu_busctl

Interface
REQ-001 SHALL have parameter DIV, default 8: clock cycles per CPU T-state; even, 4..254.
REQ-002 SHALL have parameter MEM_WS, default 1: wait states per memory access, 0..7.
REQ-003 SHALL have parameter IO_WS, default 2: wait states per I/O access, 0..7.
REQ-004 SHALL have parameter INT_LEN, default 32: interrupt pulse length in T-states, 1..255.
REQ-005 SHALL have ports:
  - clock  in  1  system clock; single clock domain.
  - reset  in  1  synchronous, active-low.
  - turbo  in  1  selects DIV/2 when high.
  - vsync  in  1  frame interrupt trigger; rising edge.
  - mreq   in  1  CPU MREQ_n.
  - iorq   in  1  CPU IORQ_n.
  - rfsh   in  1  CPU RFSH_n.
  - m1     in  1  CPU M1_n.
  - cep    out 1  positive-phase clock enable.
  - cen    out 1  negative-phase clock enable.
  - wait_n out 1  CPU WAIT_n.
  - int_n  out 1  CPU INT_n.

Function
REQ-006 SHALL keep phase counter cnt over 0..D-1, where D = DIV when turbo=0 and DIV/2 when turbo=1.
REQ-007 SHALL drive cep high for exactly one clock when cnt==0, and cen high for exactly one clock when cnt==D/2; never both in the same clock.
REQ-008 SHALL sample turbo only at cnt==D-1; a mid-period change SHALL NOT shorten or stretch the current period.
REQ-009 SHALL treat, sampled on cep:
  - a memory access as mreq=0 and rfsh=1;
  - an I/O access as iorq=0 and m1=1;
  - refresh and interrupt-acknowledge cycles SHALL never insert waits.
REQ-010 SHALL load wait counter wc with MEM_WS or IO_WS at the first cep where an access is seen and the previous cep saw none (access start).
REQ-011 SHALL drive wait_n=0 while wc!=0, decrement wc on each cep, and drive wait_n=1 from the clock after wc reaches 0.
REQ-012 SHALL never drive wait_n low when the applicable WS is 0.
REQ-013 SHALL not re-arm wc until one cep sees mreq=1 and iorq=1; back-to-back accesses without such a gap SHALL get no extra waits.
REQ-014 SHALL, on a vsync rising edge (registered edge detect, 1-clock latency), drive int_n=0 and load interrupt counter ic=INT_LEN.
REQ-015 SHALL decrement ic on each cep and release int_n=1 when ic reaches 0.
REQ-016 SHALL release int_n=1 and clear ic on acknowledge (m1=0 and iorq=0 sampled on cep).
REQ-017 SHALL let a vsync edge during an active pulse reload ic=INT_LEN; a vsync edge coinciding with acknowledge SHALL win, so the pulse restarts.

Reset
REQ-018 SHALL, while reset=0 at a clock edge, clear cnt, wc and ic, clear the vsync edge register, and drive cep=0, cen=0, wait_n=1, int_n=1.
REQ-019 SHALL, on reset mid-access or mid-pulse, abort the access or pulse with no residual wait or interrupt; the first cep SHALL occur on the clock after reset deasserts.

Configuration
REQ-020 SHALL compile the wait-state logic (REQ-009..013) only when macro CPU_BUSCTL_WAIT_EN is defined.
REQ-021 SHALL, without CPU_BUSCTL_WAIT_EN, tie wait_n to 1 and instantiate no wc logic; MEM_WS and IO_WS SHALL then be ignored.

Structure
REQ-022 SHALL take from shared package cpu_pkg:
  - constants CPU_CNT_W=8, CPU_WS_W=3, CPU_IC_W=8;
  - a typedef for the access kind (none/mem/io).
REQ-023 SHALL place the divider (REQ-006..008) in sub-module cpu_cegen; wait and interrupt logic SHALL stay in cpu_busctl.

Verification
REQ-024 SHALL cover: DIV=8, turbo=0 -> cep every 8 clocks, cen 4 clocks after each cep; set turbo=1 at cnt=3 -> current period completes at 8, then period 4.
REQ-025 SHALL cover: MEM_WS=1, IO_WS=2, memory read -> wait_n low for exactly 1 cep period; I/O write -> 2 periods; refresh cycle (rfsh=0) -> wait_n stays 1.
REQ-026 SHALL cover: INT_LEN=32, vsync pulse, no acknowledge -> int_n low for exactly 32 cep periods.
REQ-027 SHALL cover: INT_LEN=32, acknowledge (m1=0, iorq=0) at cep 5 -> int_n=1 on the next clock; a vsync edge in the same cep -> int_n stays 0 with ic=32.
REQ-028 SHALL cover: reset=0 during a wait and an active interrupt -> next clock wait_n=1, int_n=1, cep=0; after release, first cep one clock later.
REQ-029 SHALL cover: build without CPU_BUSCTL_WAIT_EN, MEM_WS=7 -> wait_n constant 1 across 100 accesses.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the bus access classification used by the
// CPU bus controller. The decode helper is consumed only by the wait-state
// logic, which is built when CPU_BUSCTL_WAIT_EN is defined.
package cpu_pkg;

    localparam int CPU_CNT_W = 8;   // phase counter width (DIV up to 254)
    localparam int CPU_WS_W  = 3;   // wait counter width (0..7 wait states)
    localparam int CPU_IC_W  = 8;   // interrupt counter width (1..255 T-states)

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_MEM  = 2'd1,
        ACC_IO   = 2'd2
    } acc_kind_t;

    // Classify the CPU control strobes (all active-low). Refresh (rfsh low)
    // and interrupt acknowledge (m1 low with iorq low) are not accesses.
    function automatic acc_kind_t acc_decode(input logic mreq, input logic iorq,
                                             input logic rfsh, input logic m1);
        acc_kind_t kind;
        kind = ACC_NONE;
        if (!mreq && rfsh) begin
            kind = ACC_MEM;
        end else if (!iorq && m1) begin
            kind = ACC_IO;
        end
        return kind;
    endfunction

endpackage

// File: rtl/cpu_cegen.sv
// cpu_cegen: T-state clock-enable generator. Divides the system clock by DIV
// (or DIV/2 in turbo) and emits single-cycle cep/cen strobes half a period
// apart. The turbo select is latched only on the last phase so a period is
// never cut short or stretched.
module cpu_cegen
    import cpu_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic turbo,
    output logic cep,
    output logic cen
);

    localparam logic [CPU_CNT_W-1:0] LAST_FULL  = CPU_CNT_W'(DIV - 1);
    localparam logic [CPU_CNT_W-1:0] LAST_TURBO = CPU_CNT_W'((DIV / 2) - 1);
    localparam logic [CPU_CNT_W-1:0] HALF_FULL  = CPU_CNT_W'(DIV / 2);
    localparam logic [CPU_CNT_W-1:0] HALF_TURBO = CPU_CNT_W'((DIV / 2) / 2);
    localparam logic [CPU_CNT_W-1:0] CNT_ONE    = CPU_CNT_W'(1);

    logic [CPU_CNT_W-1:0] cnt_reg;
    logic                 turbo_sel_reg;
    logic                 cep_reg;
    logic                 cen_reg;
    logic [CPU_CNT_W-1:0] last_next;
    logic [CPU_CNT_W-1:0] half_next;

    // Period end and mid-point for the period currently running.
    always_comb begin
        last_next = turbo_sel_reg ? LAST_TURBO : LAST_FULL;
        half_next = turbo_sel_reg ? HALF_TURBO : HALF_FULL;
    end

    // Phase counter with registered strobes; turbo is latched at wrap only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_reg       <= '0;
            turbo_sel_reg <= 1'b0;
            cep_reg       <= 1'b0;
            cen_reg       <= 1'b0;
        end else begin
            cep_reg <= (cnt_reg == '0);
            cen_reg <= (cnt_reg == half_next);
            if (cnt_reg == last_next) begin
                cnt_reg       <= '0;
                turbo_sel_reg <= turbo;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign cep = cep_reg;
    assign cen = cen_reg;

endmodule

// File: rtl/cpu_busctl.sv
// cpu_busctl: CPU bus controller. Generates the T-state clock enables, inserts
// memory/I/O wait states and produces the frame interrupt pulse.
// Wait-state insertion is built only when CPU_BUSCTL_WAIT_EN is defined;
// otherwise wait_n is tied high and MEM_WS/IO_WS have no effect.
module cpu_busctl
    import cpu_pkg::*;
#(
    parameter int DIV     = 8,
    parameter int MEM_WS  = 1,
    parameter int IO_WS   = 2,
    parameter int INT_LEN = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic turbo,
    input  logic vsync,
    input  logic mreq,
    input  logic iorq,
    input  logic rfsh,
    input  logic m1,
    output logic cep,
    output logic cen,
    output logic wait_n,
    output logic int_n
);

    localparam logic [CPU_IC_W-1:0] IC_LOAD = CPU_IC_W'(INT_LEN);
    localparam logic [CPU_IC_W-1:0] IC_ONE  = CPU_IC_W'(1);

    logic cep_w;
    logic cen_w;

    cpu_cegen #(
        .DIV(DIV)
    ) u_cegen (
        .clock(clock),
        .reset(reset),
        .turbo(turbo),
        .cep  (cep_w),
        .cen  (cen_w)
    );

    assign cep = cep_w;
    assign cen = cen_w;

    // ------------------------------------------------------------------
    // Frame interrupt
    // ------------------------------------------------------------------
    logic                vsync_reg;
    logic [CPU_IC_W-1:0] ic_reg;
    logic                int_n_reg;
    logic                vsync_rise;
    logic                int_ack;

    assign vsync_rise = vsync & ~vsync_reg;
    assign int_ack    = ~m1 & ~iorq;

    // Interrupt pulse: a new vsync edge always (re)starts it, even over an
    // acknowledge in the same T-state; otherwise ack or timeout ends it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vsync_reg <= 1'b0;
            ic_reg    <= '0;
            int_n_reg <= 1'b1;
        end else begin
            vsync_reg <= vsync;
            if (vsync_rise) begin
                ic_reg    <= IC_LOAD;
                int_n_reg <= 1'b0;
            end else if (cep_w && int_ack) begin
                ic_reg    <= '0;
                int_n_reg <= 1'b1;
            end else if (cep_w && (ic_reg != '0)) begin
                ic_reg    <= ic_reg - IC_ONE;
                int_n_reg <= (ic_reg == IC_ONE);
            end
        end
    end

    assign int_n = int_n_reg;

    // ------------------------------------------------------------------
    // Wait-state insertion
    // ------------------------------------------------------------------
`ifdef CPU_BUSCTL_WAIT_EN
    localparam logic [CPU_WS_W-1:0] MEM_LOAD = CPU_WS_W'(MEM_WS);
    localparam logic [CPU_WS_W-1:0] IO_LOAD  = CPU_WS_W'(IO_WS);
    localparam logic [CPU_WS_W-1:0] WC_ONE   = CPU_WS_W'(1);

    acc_kind_t             acc_kind;
    logic [CPU_WS_W-1:0]   ws_next;
    logic [CPU_WS_W-1:0]   wc_reg;
    logic                  armed_reg;
    logic                  wait_n_reg;

    // Wait count applicable to whatever access is on the bus right now.
    always_comb begin
        acc_kind = acc_decode(mreq, iorq, rfsh, m1);
        ws_next  = (acc_kind == ACC_IO) ? IO_LOAD : MEM_LOAD;
    end

    // Wait counter: armed by an idle T-state (mreq and iorq both high), it
    // loads once at the start of an access and counts down per T-state, so
    // back-to-back accesses with no idle gap never get extra waits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wc_reg     <= '0;
            armed_reg  <= 1'b1;
            wait_n_reg <= 1'b1;
        end else if (cep_w) begin
            if (mreq && iorq) begin
                armed_reg <= 1'b1;
            end
            if ((acc_kind != ACC_NONE) && armed_reg) begin
                armed_reg  <= 1'b0;
                wc_reg     <= ws_next;
                wait_n_reg <= (ws_next == '0);
            end else if (wc_reg != '0) begin
                wc_reg     <= wc_reg - WC_ONE;
                wait_n_reg <= (wc_reg == WC_ONE);
            end
        end
    end

    assign wait_n = wait_n_reg;
`else
    localparam int WS_UNUSED = MEM_WS + IO_WS;
    logic unused_bus;

    // Without wait-state support the CPU is never held.
    assign unused_bus = &{1'b0, mreq, rfsh};
    assign wait_n     = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_busctl.sv
// tb_cpu_busctl: self-checking bench for cpu_busctl. Every clock the DUT
// outputs are compared with a reference model that tracks absolute edge
// times for the T-state schedule and "release at cep number N" deadlines for
// the wait and interrupt windows. Works with or without CPU_BUSCTL_WAIT_EN.
module tb_cpu_busctl;

    localparam int DIV     = 8;
    localparam int MEM_WS  = 1;
    localparam int IO_WS   = 2;
    localparam int INT_LEN = 32;

    logic clock = 1'b0;
    logic reset, turbo, vsync, mreq, iorq, rfsh, m1;
    logic cep, cen, wait_n, int_n;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_busctl #(
        .DIV    (DIV),
        .MEM_WS (MEM_WS),
        .IO_WS  (IO_WS),
        .INT_LEN(INT_LEN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .turbo (turbo),
        .vsync (vsync),
        .mreq  (mreq),
        .iorq  (iorq),
        .rfsh  (rfsh),
        .m1    (m1),
        .cep   (cep),
        .cen   (cen),
        .wait_n(wait_n),
        .int_n (int_n)
    );

    always #5 clock = ~clock;

    // Reference model state
    int t_edge     = 0;   // index of the current active clock edge
    int s_edge     = 0;   // edge at which the running T-state period began
    int per_len    = DIV; // length of the running period in clocks
    int per_next   = DIV; // length chosen for the following period
    bit started    = 1'b0;
    bit m_cep      = 1'b0;
    bit m_cen      = 1'b0;
    int cep_count  = 0;   // number of cep strobes seen by the bus logic
    int wait_until = 0;   // wait_n is low until cep_count reaches this
    int int_until  = 0;   // int_n is low until cep_count reaches this
    bit armed      = 1'b1;
    bit vprev      = 1'b0;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b, want %b", tag, $time, got, exp);
        end
    endtask

    // Advance the model across one active clock edge using current inputs.
    task automatic model_edge();
        bit sampled;
        bit rise;
        bit is_mem;
        bit is_io;
        t_edge++;
        if (!reset) begin
            started    = 1'b0;
            m_cep      = 1'b0;
            m_cen      = 1'b0;
            wait_until = cep_count;
            int_until  = cep_count;
            armed      = 1'b1;
            vprev      = 1'b0;
            return;
        end
        sampled = m_cep;
        rise    = vsync && !vprev;
        vprev   = vsync;
        if (sampled) cep_count++;
`ifdef CPU_BUSCTL_WAIT_EN
        if (sampled) begin
            is_mem = !mreq && rfsh;
            is_io  = !iorq && m1;
            if ((is_mem || is_io) && armed) begin
                wait_until = cep_count + (is_mem ? MEM_WS : IO_WS);
                armed      = 1'b0;
            end else if (mreq && iorq) begin
                armed = 1'b1;
            end
        end
`else
        is_mem = 1'b0;
        is_io  = 1'b0;
`endif
        if (rise) begin
            int_until = cep_count + INT_LEN;
        end else if (sampled && !m1 && !iorq) begin
            int_until = cep_count;
        end
        if (!started) begin
            started  = 1'b1;
            s_edge   = t_edge;
            per_len  = DIV;
            per_next = DIV;
        end else if (t_edge == s_edge + per_len) begin
            s_edge  = t_edge;
            per_len = per_next;
        end
        if (t_edge == s_edge + per_len - 1) per_next = turbo ? DIV / 2 : DIV;
        m_cep = (t_edge == s_edge);
        m_cen = (t_edge == s_edge + per_len / 2);
    endtask

    // One clock: model sees the edge, outputs are compared on the falling edge.
    task automatic cycle();
        bit exp_wait;
        @(posedge clock);
        model_edge();
        @(negedge clock);
`ifdef CPU_BUSCTL_WAIT_EN
        exp_wait = (cep_count >= wait_until);
`else
        exp_wait = 1'b1;
`endif
        check_eq("cep", cep, m_cep);
        check_eq("cen", cen, m_cen);
        check_eq("wait_n", wait_n, exp_wait);
        check_eq("int_n", int_n, cep_count >= int_until);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model says a cep strobe is visible (bounded).
    task automatic wait_cep();
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            if (m_cep) break;
            cycle();
        end
        check_eq("cep_align", cep, 1'b1);
    endtask

    task automatic set_bus(input logic mq, input logic iq, input logic rf, input logic mo);
        mreq = mq;
        iorq = iq;
        rfsh = rf;
        m1   = mo;
    endtask

    initial begin
        reset = 1'b0;
        turbo = 1'b0;
        vsync = 1'b0;
        set_bus(1, 1, 1, 1);
        run(4);
        $display("reset: held low 4 clocks");
        reset = 1'b1;
        run(5 * DIV);
        $display("divider: idle bus, turbo off");

        // Switch turbo on mid-period (phase 3); that period must still run DIV.
        wait_cep();
        run(2);
        turbo = 1'b1;
        run(6 * DIV);
        turbo = 1'b0;
        run(4 * DIV);
        $display("divider: turbo raised at phase 3 and dropped again");

        // Memory read, I/O write, refresh; each followed by an idle gap.
        wait_cep();
        set_bus(0, 1, 1, 1);
        run(3 * DIV);
        set_bus(1, 1, 1, 1);
        run(2 * DIV);
        $display("bus: memory read");
        set_bus(1, 0, 1, 1);
        run(4 * DIV);
        set_bus(1, 1, 1, 1);
        run(2 * DIV);
        $display("bus: io write");
        set_bus(0, 1, 0, 1);
        run(3 * DIV);
        set_bus(1, 1, 1, 1);
        run(2 * DIV);
        $display("bus: refresh");
        // Back-to-back memory then I/O without an idle gap.
        set_bus(0, 1, 1, 0);
        run(2 * DIV);
        set_bus(1, 0, 1, 1);
        run(3 * DIV);
        set_bus(1, 1, 1, 1);
        run(2 * DIV);
        $display("bus: back-to-back mem then io");

        // Full-length interrupt pulse with no acknowledge.
        vsync = 1'b1;
        run(3);
        vsync = 1'b0;
        run((INT_LEN + 3) * DIV);
        $display("int: unacknowledged pulse");

        // Acknowledge on the 5th cep of a pulse.
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_cep();
            if (k < 5) cycle();
        end
        set_bus(1, 0, 1, 0);
        cycle();
        set_bus(1, 1, 1, 1);
        run(2 * DIV);
        $display("int: acknowledged at cep 5");

        // Acknowledge and a fresh vsync edge in the same T-state.
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        run(3 * DIV);
        wait_cep();
        set_bus(1, 0, 1, 0);
        vsync = 1'b1;
        cycle();
        set_bus(1, 1, 1, 1);
        vsync = 1'b0;
        run((INT_LEN + 3) * DIV);
        $display("int: vsync edge coinciding with acknowledge");

        // Reset during an I/O wait and an active interrupt.
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        wait_cep();
        set_bus(1, 0, 1, 1);
        run(DIV + 3);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_bus(1, 1, 1, 1);
        run(3 * DIV);
        $display("reset: mid-wait and mid-interrupt");

        // 100 memory accesses with the worst-case idle pattern.
        for (int a = 0; a < 100; a++) begin
            set_bus(0, 1, 1, 1);
            run(DIV);
            set_bus(1, 1, 1, 1);
            run(DIV);
        end
        $display("bus: 100 memory accesses");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(4))
                    0: set_bus(1, 1, 1, 1);
                    1: set_bus(0, 1, 1, 1'($urandom_range(1)));
                    2: set_bus(1, 0, 1, 1);
                    3: set_bus(0, 1, 0, 1);
                    default: set_bus(1, 0, 1, 0);
                endcase
            end
            if ($urandom_range(29) == 0) vsync = ~vsync;
            if ($urandom_range(199) == 0) turbo = ~turbo;
            reset = ($urandom_range(599) != 0);
            cycle();
        end
        reset = 1'b1;
        $display("random: 3000 clocks of mixed traffic");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
